// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned CW_DEF      = 8;
  localparam int unsigned AW          = 32;
  localparam int unsigned DW          = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  // Command held stable on the memory side until Mem_Ack
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_wdog.sv
// Busy-cycle watchdog: counts cycles without Mem_Ack and flags the cycle whose
// count would reach TIMEOUT, so the arbiter can abort on that same edge.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CW      = CW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with a
// flush drain state and a sticky timeout error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CW      = CW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          IF_Req,
  input  logic [AW-1:0] IF_Addr,
  input  logic          IF_Flush,
  output logic          IF_Valid,
  output logic [DW-1:0] IF_RData,
  output logic          IF_Stall,
  input  logic          MEM_Read,
  input  logic          MEM_Write,
  input  logic [AW-1:0] MEM_Addr,
  input  logic [DW-1:0] MEM_WData,
  output logic          MEM_Done,
  output logic [DW-1:0] MEM_RData,
  output logic          MEM_Stall,
  output logic          Mem_Req,
  output logic          Mem_We,
  output logic [AW-1:0] Mem_Addr,
  output logic [DW-1:0] Mem_WData,
  input  logic          Mem_Ack,
  input  logic [DW-1:0] Mem_RData,
  output logic          Mem_Err
);

  arb_state_e    state, state_d;
  mem_cmd_t      cmd_q, cmd_d;
  logic          if_valid_d, mem_done_d, err_d;
  logic [DW-1:0] if_rdata_d, mem_rdata_d;
  logic          wd_clear, wd_enable, wd_expired;

  assign wd_enable = (state != ST_IDLE) && !Mem_Ack;

  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_wdog (
    .clk     (CLK),
    .rst     (RESET),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  assign IF_Stall  = IF_Req && !IF_Valid;
  assign MEM_Stall = (MEM_Read || MEM_Write) && !MEM_Done;
  assign Mem_We    = cmd_q.we;
  assign Mem_Addr  = cmd_q.addr;
  assign Mem_WData = cmd_q.wdata;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      Mem_Req   <= 1'b0;
      IF_Valid  <= 1'b0;
      MEM_Done  <= 1'b0;
      Mem_Err   <= 1'b0;
      IF_RData  <= '0;
      MEM_RData <= '0;
    end else begin
      state     <= state_d;
      cmd_q     <= cmd_d;
      Mem_Req   <= (state_d != ST_IDLE);
      IF_Valid  <= if_valid_d;
      MEM_Done  <= mem_done_d;
      Mem_Err   <= err_d;
      IF_RData  <= if_rdata_d;
      MEM_RData <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state;
    cmd_d       = cmd_q;
    if_valid_d  = 1'b0;
    mem_done_d  = 1'b0;
    err_d       = Mem_Err;
    if_rdata_d  = IF_RData;
    mem_rdata_d = MEM_RData;
    wd_clear    = 1'b0;

    case (state)
      // A port whose done pulse is showing may not restart; data beats fetch
      ST_IDLE: begin
        if ((MEM_Read || MEM_Write) && !MEM_Done) begin
          state_d     = ST_DATA;
          cmd_d.we    = MEM_Write;
          cmd_d.addr  = MEM_Addr;
          cmd_d.wdata = MEM_WData;
          wd_clear    = 1'b1;
        end else if (IF_Req && !IF_Valid) begin
          state_d    = ST_FETCH;
          cmd_d.we   = 1'b0;
          cmd_d.addr = IF_Addr;
          wd_clear   = 1'b1;
        end
      end
      // A flush arriving with the ack or timeout just suppresses the pulse
      ST_FETCH: begin
        if (Mem_Ack) begin
          state_d = ST_IDLE;
          if (!IF_Flush) begin
            if_valid_d = 1'b1;
            if_rdata_d = Mem_RData;
          end
        end else if (wd_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          if (!IF_Flush) begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end
        end else if (IF_Flush) begin
          state_d  = ST_DRAIN;
          wd_clear = 1'b1;
        end
      end
      ST_DATA: begin
        if (Mem_Ack) begin
          state_d    = ST_IDLE;
          mem_done_d = 1'b1;
          if (!cmd_q.we) begin
            mem_rdata_d = Mem_RData;
          end
        end else if (wd_expired) begin
          state_d     = ST_IDLE;
          err_d       = 1'b1;
          mem_done_d  = 1'b1;
          mem_rdata_d = '0;
        end
      end
      ST_DRAIN: begin
        if (Mem_Ack) begin
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT overridden to 4).
module tb_mem_arbiter;

  logic        CLK, RESET;
  logic        IF_Req, IF_Flush, IF_Valid, IF_Stall;
  logic [31:0] IF_Addr, IF_RData;
  logic        MEM_Read, MEM_Write, MEM_Done, MEM_Stall;
  logic [31:0] MEM_Addr, MEM_WData, MEM_RData;
  logic        Mem_Req, Mem_We, Mem_Ack, Mem_Err;
  logic [31:0] Mem_Addr, Mem_WData, Mem_RData;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.TIMEOUT(4), .CW(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Flush(IF_Flush),
    .IF_Valid(IF_Valid), .IF_RData(IF_RData), .IF_Stall(IF_Stall),
    .MEM_Read(MEM_Read), .MEM_Write(MEM_Write), .MEM_Addr(MEM_Addr),
    .MEM_WData(MEM_WData), .MEM_Done(MEM_Done), .MEM_RData(MEM_RData),
    .MEM_Stall(MEM_Stall),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData),
    .Mem_Err(Mem_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1ns after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; IF_Req = 0; IF_Addr = 0; IF_Flush = 0; MEM_Read = 0; MEM_Write = 0;
    MEM_Addr = 0; MEM_WData = 0; Mem_Ack = 0; Mem_RData = 0;
    #1;
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL rst_req got=%h exp=0", Mem_Req); end
    total++; if (Mem_Err !== 1'b0) begin bad++; $display("FAIL rst_err got=%h exp=0", Mem_Err); end
    total++; if (Mem_Addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", Mem_Addr); end
    total++; if ({IF_Valid, MEM_Done, Mem_We} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b exp=000", {IF_Valid, MEM_Done, Mem_We}); end
    total++; if ({IF_RData, MEM_RData} !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", {IF_RData, MEM_RData}); end
    step(); step();
    RESET = 1'b0;
    step();
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL rst_idle got=%h exp=0", Mem_Req); end
  endtask

  task automatic test_fetch();
    IF_Req = 1; IF_Addr = 32'h4;
    #1;
    total++; if (IF_Stall !== 1'b1) begin bad++; $display("FAIL fetch_stall got=%h exp=1", IF_Stall); end
    step();
    total++; if (Mem_Req !== 1'b1) begin bad++; $display("FAIL fetch_req got=%h exp=1", Mem_Req); end
    total++; if (Mem_Addr !== 32'h4) begin bad++; $display("FAIL fetch_addr got=%h exp=4", Mem_Addr); end
    total++; if (Mem_We !== 1'b0) begin bad++; $display("FAIL fetch_we got=%h exp=0", Mem_We); end
    step();
    step();
    total++; if (IF_Valid !== 1'b0) begin bad++; $display("FAIL fetch_early got=%h exp=0", IF_Valid); end
    total++; if (Mem_Req !== 1'b1) begin bad++; $display("FAIL fetch_hold got=%h exp=1", Mem_Req); end
    Mem_Ack = 1; Mem_RData = 32'h012A4020;
    step();
    total++; if (IF_Valid !== 1'b1) begin bad++; $display("FAIL fetch_valid got=%h exp=1", IF_Valid); end
    total++; if (IF_RData !== 32'h012A4020) begin bad++; $display("FAIL fetch_rdata got=%h exp=012a4020", IF_RData); end
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL fetch_idle got=%h exp=0", Mem_Req); end
    total++; if (IF_Stall !== 1'b0) begin bad++; $display("FAIL fetch_unstall got=%h exp=0", IF_Stall); end
    Mem_Ack = 0; IF_Req = 0;
    step();
    total++; if (IF_Valid !== 1'b0) begin bad++; $display("FAIL fetch_onecycle got=%h exp=0", IF_Valid); end
  endtask

  task automatic test_back_to_back();
    MEM_Read = 1; MEM_Addr = 32'h100;
    #1;
    total++; if (MEM_Stall !== 1'b1) begin bad++; $display("FAIL b2b_stall got=%h exp=1", MEM_Stall); end
    step();
    total++; if ({Mem_Req, Mem_We} !== 2'b10) begin bad++; $display("FAIL b2b_req got=%b exp=10", {Mem_Req, Mem_We}); end
    total++; if (Mem_Addr !== 32'h100) begin bad++; $display("FAIL b2b_addr got=%h exp=100", Mem_Addr); end
    Mem_Ack = 1; Mem_RData = 32'hCAFEF00D;
    step();
    total++; if (MEM_Done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%h exp=1", MEM_Done); end
    total++; if (MEM_RData !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_rdata got=%h exp=cafef00d", MEM_RData); end
    total++; if (MEM_Stall !== 1'b0) begin bad++; $display("FAIL b2b_unstall got=%h exp=0", MEM_Stall); end
    Mem_Ack = 0;
    step();
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL b2b_nodup got=%h exp=0", Mem_Req); end
    total++; if (MEM_Done !== 1'b0) begin bad++; $display("FAIL b2b_done1 got=%h exp=0", MEM_Done); end
    MEM_Addr = 32'h104;
    step();
    total++; if (Mem_Addr !== 32'h104 || Mem_Req !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h/%h exp=104/1", Mem_Addr, Mem_Req); end
    Mem_Ack = 1; Mem_RData = 32'h12345678;
    step();
    total++; if (MEM_RData !== 32'h12345678 || MEM_Done !== 1'b1) begin bad++; $display("FAIL b2b_rdata2 got=%h/%h exp=12345678/1", MEM_RData, MEM_Done); end
    Mem_Ack = 0; MEM_Read = 0;
    step();
    total++; if ({Mem_Req, MEM_Done} !== 2'b00) begin bad++; $display("FAIL b2b_end got=%b exp=00", {Mem_Req, MEM_Done}); end
  endtask

  task automatic test_conflict();
    IF_Req = 1; IF_Addr = 32'h20;
    MEM_Write = 1; MEM_Addr = 32'h10; MEM_WData = 32'hDEADBEEF;
    step();
    total++; if ({Mem_Req, Mem_We} !== 2'b11) begin bad++; $display("FAIL conf_we got=%b exp=11", {Mem_Req, Mem_We}); end
    total++; if (Mem_Addr !== 32'h10) begin bad++; $display("FAIL conf_addr got=%h exp=10", Mem_Addr); end
    total++; if (Mem_WData !== 32'hDEADBEEF) begin bad++; $display("FAIL conf_wdata got=%h exp=deadbeef", Mem_WData); end
    total++; if ({IF_Stall, MEM_Stall} !== 2'b11) begin bad++; $display("FAIL conf_stalls got=%b exp=11", {IF_Stall, MEM_Stall}); end
    Mem_Ack = 1; Mem_RData = 32'h55555555;
    step();
    total++; if (MEM_Done !== 1'b1) begin bad++; $display("FAIL conf_done got=%h exp=1", MEM_Done); end
    total++; if (MEM_RData !== 32'h12345678) begin bad++; $display("FAIL conf_wr_rdata got=%h exp=12345678", MEM_RData); end
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL conf_gap got=%h exp=0", Mem_Req); end
    Mem_Ack = 0;
    step();
    total++; if ({Mem_Req, Mem_We} !== 2'b10) begin bad++; $display("FAIL conf_fetch got=%b exp=10", {Mem_Req, Mem_We}); end
    total++; if (Mem_Addr !== 32'h20) begin bad++; $display("FAIL conf_faddr got=%h exp=20", Mem_Addr); end
    MEM_Write = 0;
    Mem_Ack = 1; Mem_RData = 32'h11112222;
    step();
    total++; if (IF_Valid !== 1'b1 || IF_RData !== 32'h11112222) begin bad++; $display("FAIL conf_fvalid got=%h/%h exp=1/11112222", IF_Valid, IF_RData); end
    total++; if (MEM_Done !== 1'b0) begin bad++; $display("FAIL conf_nodone got=%h exp=0", MEM_Done); end
    Mem_Ack = 0; IF_Req = 0;
    step();
  endtask

  task automatic test_flush();
    IF_Req = 1; IF_Addr = 32'h40;
    step();
    total++; if (Mem_Req !== 1'b1) begin bad++; $display("FAIL flush_fetch got=%h exp=1", Mem_Req); end
    IF_Flush = 1;
    step();
    IF_Flush = 0; IF_Req = 0;
    total++; if (Mem_Req !== 1'b1 || Mem_Addr !== 32'h40) begin bad++; $display("FAIL flush_drain got=%h/%h exp=1/40", Mem_Req, Mem_Addr); end
    step();
    total++; if (Mem_Req !== 1'b1) begin bad++; $display("FAIL flush_hold got=%h exp=1", Mem_Req); end
    total++; if (IF_Valid !== 1'b0) begin bad++; $display("FAIL flush_novalid1 got=%h exp=0", IF_Valid); end
    Mem_Ack = 1; Mem_RData = 32'hBAD0BAD0;
    step();
    Mem_Ack = 0;
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL flush_idle got=%h exp=0", Mem_Req); end
    total++; if (IF_Valid !== 1'b0) begin bad++; $display("FAIL flush_novalid got=%h exp=0", IF_Valid); end
    total++; if (IF_RData !== 32'h11112222) begin bad++; $display("FAIL flush_rdata got=%h exp=11112222", IF_RData); end
    total++; if (Mem_Err !== 1'b0) begin bad++; $display("FAIL flush_err got=%h exp=0", Mem_Err); end
    step();
  endtask

  task automatic test_timeout();
    MEM_Read = 1; MEM_Addr = 32'h80;
    step();
    total++; if (Mem_Req !== 1'b1) begin bad++; $display("FAIL to_req got=%h exp=1", Mem_Req); end
    for (int i = 2; i <= 4; i++) begin
      step();
      total++; if ({Mem_Req, Mem_Err, MEM_Done} !== 3'b100) begin bad++; $display("FAIL to_busy%0d got=%b exp=100", i, {Mem_Req, Mem_Err, MEM_Done}); end
    end
    step();
    total++; if (Mem_Err !== 1'b1) begin bad++; $display("FAIL to_err got=%h exp=1", Mem_Err); end
    total++; if (MEM_Done !== 1'b1) begin bad++; $display("FAIL to_done got=%h exp=1", MEM_Done); end
    total++; if (MEM_RData !== 32'h0) begin bad++; $display("FAIL to_rdata got=%h exp=0", MEM_RData); end
    total++; if (Mem_Req !== 1'b0) begin bad++; $display("FAIL to_idle got=%h exp=0", Mem_Req); end
    MEM_Read = 0;
    step();
    total++; if ({Mem_Err, MEM_Done} !== 2'b10) begin bad++; $display("FAIL to_sticky got=%b exp=10", {Mem_Err, MEM_Done}); end
  endtask

  task automatic test_reset_mid();
    MEM_Write = 1; MEM_Addr = 32'h200; MEM_WData = 32'h77;
    step();
    total++; if (Mem_Req !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%h exp=1", Mem_Req); end
    #2 RESET = 1'b1;
    #1;
    total++; if ({Mem_Req, Mem_We, Mem_Err} !== 3'b000) begin bad++; $display("FAIL rmid_async got=%b exp=000", {Mem_Req, Mem_We, Mem_Err}); end
    total++; if (Mem_Addr !== 32'h0) begin bad++; $display("FAIL rmid_addr got=%h exp=0", Mem_Addr); end
    MEM_Write = 0;
    step();
    RESET = 1'b0;
    Mem_Ack = 1; Mem_RData = 32'hFFFF0000;
    step();
    Mem_Ack = 0;
    total++; if ({Mem_Req, MEM_Done, IF_Valid} !== 3'b000) begin bad++; $display("FAIL rmid_nodone got=%b exp=000", {Mem_Req, MEM_Done, IF_Valid}); end
    total++; if (MEM_RData !== 32'h0) begin bad++; $display("FAIL rmid_rdata got=%h exp=0", MEM_RData); end
    step();
    total++; if ({Mem_Req, MEM_Done} !== 2'b00) begin bad++; $display("FAIL rmid_quiet got=%b exp=00", {Mem_Req, MEM_Done}); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_conflict();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
